// File: rtl/cpu_control_unit.sv
// Multicycle fetch/decode/sequence control unit for the ld/sd/add/sub datapath.
// Define CU_ADDI_EN to additionally decode addi; without it opcode 0010011 halts as illegal.
module cpu_control_unit #(
  parameter int                  WORDSIZE = 64,
  parameter logic [WORDSIZE-1:0] RESET_PC = {WORDSIZE{1'b0}}
) (
  input  logic                cu_clk,
  input  logic                cu_rst_n,
  output logic                cu_im_req,
  input  logic                cu_im_ack,
  input  logic [31:0]         cu_im_data,
  output logic [WORDSIZE-1:0] cu_pc,
  output logic [4:0]          cu_rf_addr_a,
  output logic [4:0]          cu_rf_addr_b,
  output logic [4:0]          cu_rf_write_addr,
  output logic                cu_rf_write_en,
  output logic [WORDSIZE-1:0] cu_immediate,
  output logic                cu_mux_0_sel,
  output logic                cu_mux_1_sel,
  output logic                cu_mux_2_sel,
  output logic [2:0]          cu_alu_operation,
  output logic                cu_dm_write_en,
  output logic [2:0]          cu_state,
  output logic                cu_illegal
);

  localparam logic [2:0] ST_IDLE      = 3'd0;
  localparam logic [2:0] ST_FETCH     = 3'd1;
  localparam logic [2:0] ST_DECODE    = 3'd2;
  localparam logic [2:0] ST_EXECUTE   = 3'd3;
  localparam logic [2:0] ST_WRITEBACK = 3'd4;
  localparam logic [2:0] ST_HALT      = 3'd7;

  localparam logic [2:0] K_ILL  = 3'd0;
  localparam logic [2:0] K_LD   = 3'd1;
  localparam logic [2:0] K_SD   = 3'd2;
  localparam logic [2:0] K_ADD  = 3'd3;
  localparam logic [2:0] K_SUB  = 3'd4;
  localparam logic [2:0] K_ADDI = 3'd5;

  localparam logic [WORDSIZE-1:0] PC_STEP = WORDSIZE'(3'd4);

  function automatic logic [2:0] classify(input logic [31:0] ir);
    logic [2:0] k;
    k = K_ILL;
    case (ir[6:0])
      7'b0000011: k = (ir[14:12] == 3'b011) ? K_LD : K_ILL;
      7'b0100011: k = (ir[14:12] == 3'b011) ? K_SD : K_ILL;
      7'b0110011: begin
        if (ir[14:12] == 3'b000 && ir[31:25] == 7'b0000000) begin
          k = K_ADD;
        end else if (ir[14:12] == 3'b000 && ir[31:25] == 7'b0100000) begin
          k = K_SUB;
        end else begin
          k = K_ILL;
        end
      end
`ifdef CU_ADDI_EN
      7'b0010011: k = (ir[14:12] == 3'b000) ? K_ADDI : K_ILL;
`endif
      default: k = K_ILL;
    endcase
    return k;
  endfunction

  logic [2:0]          state_r, state_nxt_s;
  logic [WORDSIZE-1:0] pc_r, pc_nxt_s;
  logic [31:0]         ir_r, ir_nxt_s;
  logic                illegal_r, illegal_nxt_s;
  logic [2:0]          kind_s, kind_nxt_s;
  logic [4:0]          rd_nxt_s, rs1_nxt_s, rs2_nxt_s;
  logic [WORDSIZE-1:0] imm_i_nxt_s, imm_s_nxt_s;

  logic                req_s, req_r;
  logic [4:0]          addr_a_s, addr_a_r, addr_b_s, addr_b_r, waddr_s, waddr_r;
  logic                rf_we_s, rf_we_r, dm_we_s, dm_we_r;
  logic [WORDSIZE-1:0] imm_s, imm_r;
  logic                mux0_s, mux0_r, mux1_s, mux1_r, mux2_s, mux2_r;
  logic [2:0]          alu_s, alu_r;

  assign kind_s      = classify(ir_r);
  assign kind_nxt_s  = classify(ir_nxt_s);
  assign rd_nxt_s    = ir_nxt_s[11:7];
  assign rs1_nxt_s   = ir_nxt_s[19:15];
  assign rs2_nxt_s   = ir_nxt_s[24:20];
  assign imm_i_nxt_s = {{(WORDSIZE-12){ir_nxt_s[31]}}, ir_nxt_s[31:20]};
  assign imm_s_nxt_s = {{(WORDSIZE-12){ir_nxt_s[31]}}, ir_nxt_s[31:25], ir_nxt_s[11:7]};

  // Next-state, PC, IR and sticky illegal flag.
  always_comb begin
    state_nxt_s   = state_r;
    pc_nxt_s      = pc_r;
    ir_nxt_s      = ir_r;
    illegal_nxt_s = illegal_r;
    case (state_r)
      ST_IDLE: state_nxt_s = ST_FETCH;
      ST_FETCH: begin
        if (cu_im_ack) begin
          ir_nxt_s    = cu_im_data;
          state_nxt_s = ST_DECODE;
        end else begin
          state_nxt_s = ST_FETCH;
        end
      end
      ST_DECODE: begin
        if (kind_s == K_ILL) begin
          illegal_nxt_s = 1'b1;
          state_nxt_s   = ST_HALT;
        end else begin
          state_nxt_s   = ST_EXECUTE;
        end
      end
      ST_EXECUTE: begin
        if (kind_s == K_LD) begin
          state_nxt_s = ST_WRITEBACK;
        end else begin
          pc_nxt_s    = pc_r + PC_STEP;
          state_nxt_s = ST_FETCH;
        end
      end
      ST_WRITEBACK: begin
        pc_nxt_s    = pc_r + PC_STEP;
        state_nxt_s = ST_FETCH;
      end
      ST_HALT: state_nxt_s = ST_HALT;
      default: begin
        state_nxt_s   = ST_HALT;
        illegal_nxt_s = 1'b1;
      end
    endcase
  end

  // Datapath controls for the upcoming state, so every output leaves a flop.
  always_comb begin
    req_s    = (state_nxt_s == ST_FETCH);
    addr_a_s = 5'd0;
    addr_b_s = 5'd0;
    waddr_s  = 5'd0;
    rf_we_s  = 1'b0;
    dm_we_s  = 1'b0;
    imm_s    = {WORDSIZE{1'b0}};
    mux0_s   = 1'b0;
    mux1_s   = 1'b0;
    mux2_s   = 1'b0;
    alu_s    = 3'b000;
    case (state_nxt_s)
      ST_DECODE, ST_EXECUTE, ST_WRITEBACK: begin
        case (kind_nxt_s)
          K_LD: begin
            addr_a_s = rs1_nxt_s;
            waddr_s  = rd_nxt_s;
            mux2_s   = 1'b1;
            imm_s    = imm_i_nxt_s;
            rf_we_s  = (state_nxt_s == ST_WRITEBACK) && (rd_nxt_s != 5'd0);
          end
          K_SD: begin
            addr_a_s = rs2_nxt_s;
            addr_b_s = rs1_nxt_s;
            mux0_s   = 1'b1;
            imm_s    = imm_s_nxt_s;
            dm_we_s  = (state_nxt_s == ST_EXECUTE);
          end
          K_ADD, K_SUB: begin
            addr_a_s = rs1_nxt_s;
            addr_b_s = rs2_nxt_s;
            waddr_s  = rd_nxt_s;
            mux1_s   = 1'b1;
            alu_s    = (kind_nxt_s == K_SUB) ? 3'b001 : 3'b000;
            rf_we_s  = (state_nxt_s == ST_EXECUTE) && (rd_nxt_s != 5'd0);
          end
          K_ADDI: begin
            addr_a_s = rs1_nxt_s;
            waddr_s  = rd_nxt_s;
            imm_s    = imm_i_nxt_s;
            rf_we_s  = (state_nxt_s == ST_EXECUTE) && (rd_nxt_s != 5'd0);
          end
          default: rf_we_s = 1'b0;
        endcase
      end
      default: dm_we_s = 1'b0;
    endcase
  end

  // State and output registers.
  always_ff @(posedge cu_clk or negedge cu_rst_n) begin
    if (!cu_rst_n) begin
      state_r   <= ST_IDLE;
      pc_r      <= RESET_PC;
      ir_r      <= 32'd0;
      illegal_r <= 1'b0;
      req_r     <= 1'b0;
      addr_a_r  <= 5'd0;
      addr_b_r  <= 5'd0;
      waddr_r   <= 5'd0;
      rf_we_r   <= 1'b0;
      dm_we_r   <= 1'b0;
      imm_r     <= {WORDSIZE{1'b0}};
      mux0_r    <= 1'b0;
      mux1_r    <= 1'b0;
      mux2_r    <= 1'b0;
      alu_r     <= 3'b000;
    end else begin
      state_r   <= state_nxt_s;
      pc_r      <= pc_nxt_s;
      ir_r      <= ir_nxt_s;
      illegal_r <= illegal_nxt_s;
      req_r     <= req_s;
      addr_a_r  <= addr_a_s;
      addr_b_r  <= addr_b_s;
      waddr_r   <= waddr_s;
      rf_we_r   <= rf_we_s;
      dm_we_r   <= dm_we_s;
      imm_r     <= imm_s;
      mux0_r    <= mux0_s;
      mux1_r    <= mux1_s;
      mux2_r    <= mux2_s;
      alu_r     <= alu_s;
    end
  end

  assign cu_im_req        = req_r;
  assign cu_pc            = pc_r;
  assign cu_rf_addr_a     = addr_a_r;
  assign cu_rf_addr_b     = addr_b_r;
  assign cu_rf_write_addr = waddr_r;
  assign cu_rf_write_en   = rf_we_r;
  assign cu_immediate     = imm_r;
  assign cu_mux_0_sel     = mux0_r;
  assign cu_mux_1_sel     = mux1_r;
  assign cu_mux_2_sel     = mux2_r;
  assign cu_alu_operation = alu_r;
  assign cu_dm_write_en   = dm_we_r;
  assign cu_state         = state_r;
  assign cu_illegal       = illegal_r;

endmodule

// File: tb/tb_cpu_control_unit.sv
// Scoreboard bench for cpu_control_unit: randomized instruction stream, field-level reference model.
module tb_cpu_control_unit;

  localparam logic [63:0] RPC = 64'hFFFF_FFFF_FFFF_FFFC;
  localparam int I_LD = 0, I_SD = 1, I_ADD = 2, I_SUB = 3, I_ADDI = 4, I_BAD = 5;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        ack = 1'b0;
  logic [31:0] data = 32'd0;
  logic        cu_im_req, cu_rf_write_en, cu_mux_0_sel, cu_mux_1_sel, cu_mux_2_sel;
  logic        cu_dm_write_en, cu_illegal;
  logic [63:0] cu_pc, cu_immediate;
  logic [4:0]  cu_rf_addr_a, cu_rf_addr_b, cu_rf_write_addr;
  logic [2:0]  cu_alu_operation, cu_state;

  cpu_control_unit #(.WORDSIZE(64), .RESET_PC(RPC)) dut (
    .cu_clk(clk), .cu_rst_n(rst_n), .cu_im_req(cu_im_req), .cu_im_ack(ack), .cu_im_data(data),
    .cu_pc(cu_pc), .cu_rf_addr_a(cu_rf_addr_a), .cu_rf_addr_b(cu_rf_addr_b),
    .cu_rf_write_addr(cu_rf_write_addr), .cu_rf_write_en(cu_rf_write_en),
    .cu_immediate(cu_immediate), .cu_mux_0_sel(cu_mux_0_sel), .cu_mux_1_sel(cu_mux_1_sel),
    .cu_mux_2_sel(cu_mux_2_sel), .cu_alu_operation(cu_alu_operation),
    .cu_dm_write_en(cu_dm_write_en), .cu_state(cu_state), .cu_illegal(cu_illegal)
  );

  always #5 clk = ~clk;

  typedef struct {
    int kind; int rd; int rs1; int rs2; int imm; int delay; logic [31:0] raw;
  } instr_t;

  typedef struct {
    logic [31:0] ir; bit illegal; logic [63:0] pc;
    logic [4:0] a; logic [4:0] b; logic [4:0] w; bit chk_b; bit chk_w; bit chk_m2;
    logic [63:0] imm; logic m0; logic m1; logic m2; logic [2:0] alu;
    int rf_pulses; int rf_state; int dm_pulses; int fetch_cycles; int post_cycles;
  } exp_t;

  instr_t      prog[$];
  exp_t        sb[$];
  logic [63:0] model_pc;
  int          total = 0;
  int          bad = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  function automatic instr_t mk(int kind, int rd, int rs1, int rs2, int imm, int delay);
    instr_t i;
    i.kind = kind; i.rd = rd; i.rs1 = rs1; i.rs2 = rs2; i.imm = imm; i.delay = delay;
    i.raw = 32'd0;
    return i;
  endfunction

  function automatic logic [31:0] encode(instr_t i);
    logic [11:0] im;
    logic [31:0] r;
    im = 12'(i.imm);
    case (i.kind)
      I_LD:    r = {im, 5'(i.rs1), 3'b011, 5'(i.rd), 7'b0000011};
      I_SD:    r = {im[11:5], 5'(i.rs2), 5'(i.rs1), 3'b011, im[4:0], 7'b0100011};
      I_ADD:   r = {7'b0000000, 5'(i.rs2), 5'(i.rs1), 3'b000, 5'(i.rd), 7'b0110011};
      I_SUB:   r = {7'b0100000, 5'(i.rs2), 5'(i.rs1), 3'b000, 5'(i.rd), 7'b0110011};
      I_ADDI:  r = {im, 5'(i.rs1), 3'b000, 5'(i.rd), 7'b0010011};
      default: r = i.raw;
    endcase
    return r;
  endfunction

  // Expected behaviour derived from the instruction's fields, not from its bit pattern.
  function automatic exp_t model(instr_t i, logic [63:0] pc);
    exp_t e;
    e = '{default: 0};
    e.ir = encode(i);
    e.pc = pc;
    e.fetch_cycles = i.delay + 1;
    case (i.kind)
      I_LD: begin
        e.a = 5'(i.rs1); e.w = 5'(i.rd); e.chk_w = 1; e.chk_m2 = 1; e.m2 = 1'b1;
        e.imm = longint'(i.imm); e.rf_pulses = (i.rd != 0); e.rf_state = 4; e.post_cycles = 3;
      end
      I_SD: begin
        e.a = 5'(i.rs2); e.b = 5'(i.rs1); e.chk_b = 1; e.m0 = 1'b1;
        e.imm = longint'(i.imm); e.dm_pulses = 1; e.post_cycles = 2;
      end
      I_ADD, I_SUB: begin
        e.a = 5'(i.rs1); e.b = 5'(i.rs2); e.w = 5'(i.rd); e.chk_b = 1; e.chk_w = 1; e.chk_m2 = 1;
        e.m1 = 1'b1; e.alu = (i.kind == I_SUB) ? 3'b001 : 3'b000;
        e.rf_pulses = (i.rd != 0); e.rf_state = 3; e.post_cycles = 2;
      end
`ifdef CU_ADDI_EN
      I_ADDI: begin
        e.a = 5'(i.rs1); e.w = 5'(i.rd); e.chk_w = 1; e.chk_m2 = 1;
        e.imm = longint'(i.imm); e.rf_pulses = (i.rd != 0); e.rf_state = 3; e.post_cycles = 2;
      end
`endif
      default: e.illegal = 1;
    endcase
    return e;
  endfunction

  task automatic chk_reset_outputs();
    chk("rst_pc", cu_pc, RPC);
    chk("rst_state", 64'(cu_state), 64'd0);
    chk("rst_ctrl", 64'({cu_im_req, cu_rf_addr_a, cu_rf_addr_b, cu_rf_write_addr, cu_rf_write_en,
                         cu_mux_0_sel, cu_mux_1_sel, cu_mux_2_sel, cu_alu_operation,
                         cu_dm_write_en, cu_illegal}), 64'd0);
    chk("rst_imm", cu_immediate, 64'd0);
  endtask

  task automatic chk_fields(input exp_t e);
    chk("addr_a", 64'(cu_rf_addr_a), 64'(e.a));
    if (e.chk_b) chk("addr_b", 64'(cu_rf_addr_b), 64'(e.b));
    if (e.chk_w) chk("write_addr", 64'(cu_rf_write_addr), 64'(e.w));
    chk("imm", cu_immediate, e.imm);
    chk("mux0", 64'(cu_mux_0_sel), 64'(e.m0));
    chk("mux1", 64'(cu_mux_1_sel), 64'(e.m1));
    if (e.chk_m2) chk("mux2", 64'(cu_mux_2_sel), 64'(e.m2));
    chk("alu", 64'(cu_alu_operation), 64'(e.alu));
    chk("req_low", 64'(cu_im_req), 64'd0);
    chk("pc_stable", cu_pc, e.pc);
  endtask

  // Stimulus: answers each fetch after a per-instruction delay, noise on ack otherwise.
  task automatic drive(input int n);
    for (int k = 0; k < n; k++) begin
      instr_t it;
      exp_t   e;
      bit     seen;
      it = prog.pop_front();
      seen = 0;
      for (int t = 0; t < 100; t++) begin
        if (cu_im_req) begin
          seen = 1;
          break;
        end
        ack = 1'($urandom_range(0, 1));
        data = $urandom;
        @(negedge clk);
      end
      if (!seen) begin
        chk("drv_req_timeout", 64'd0, 64'd1);
        ack = 1'b0;
        return;
      end
      e = model(it, model_pc);
      if (!e.illegal) model_pc = model_pc + 64'd4;
      sb.push_back(e);
      repeat (it.delay) begin
        ack = 1'b0;
        data = $urandom;
        @(negedge clk);
      end
      ack = 1'b1;
      data = e.ir;
      @(negedge clk);
      ack = 1'b0;
      data = $urandom;
    end
    ack = 1'b0;
  endtask

  // Monitor: each DECODE entry presents one instruction; follow it to the next FETCH.
  task automatic monitor(input int n);
    int fc = 0;
    for (int k = 0; k < n; k++) begin
      exp_t e;
      bit   got, done;
      int   post, rfp, rfs, dmp, dms;
      got = 0;
      for (int t = 0; t < 200; t++) begin
        @(negedge clk);
        if (cu_state == 3'd2) begin
          got = 1;
          break;
        end
        if (cu_state == 3'd1) fc++;
      end
      chk("decode_reached", 64'(got), 64'd1);
      if (!got) return;
      if (sb.size() == 0) begin
        chk("scoreboard_empty", 64'd0, 64'd1);
        return;
      end
      e = sb.pop_front();
      chk("fetch_cycles", 64'(fc), 64'(e.fetch_cycles));
      fc = 0;
      if (e.illegal) begin
        chk("decode_req_low", 64'(cu_im_req), 64'd0);
        @(negedge clk);
        chk("halt_illegal", 64'({cu_state, cu_illegal}), 64'({3'd7, 1'b1}));
        repeat (6) begin
          @(negedge clk);
          chk("halt_quiet", 64'({cu_im_req, cu_rf_write_en, cu_dm_write_en, cu_state}),
              64'({1'b0, 1'b0, 1'b0, 3'd7}));
        end
        continue;
      end
      post = 0; rfp = 0; rfs = 0; dmp = 0; dms = 0; done = 0;
      for (int t = 0; t < 12; t++) begin
        if (cu_state == 3'd1) begin
          done = 1;
          fc = 1;
          chk("pc_next", cu_pc, e.pc + 64'd4);
          break;
        end
        post++;
        chk_fields(e);
        if (cu_rf_write_en) begin
          rfp++;
          rfs = int'(cu_state);
        end
        if (cu_dm_write_en) begin
          dmp++;
          dms = int'(cu_state);
        end
        @(negedge clk);
      end
      chk("retired", 64'(done), 64'd1);
      chk("post_cycles", 64'(post), 64'(e.post_cycles));
      chk("rf_we_pulses", 64'(rfp), 64'(e.rf_pulses));
      if (rfp > 0) chk("rf_we_state", 64'(rfs), 64'(e.rf_state));
      chk("dm_we_pulses", 64'(dmp), 64'(e.dm_pulses));
      if (dmp > 0) chk("dm_we_state", 64'(dms), 64'd3);
    end
  endtask

  function automatic instr_t rand_instr();
    int nk;
    nk = 4;
`ifdef CU_ADDI_EN
    nk = 5;
`endif
    return mk($urandom_range(0, nk - 1), $urandom_range(0, 31), $urandom_range(0, 31),
              $urandom_range(0, 31), int'($urandom_range(0, 4095)) - 2048, $urandom_range(0, 3));
  endfunction

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int     n;
    instr_t bi;
    repeat (3) @(negedge clk);
    chk_reset_outputs();
    rst_n = 1'b1;
    #1 chk("idle_after_release", 64'(cu_state), 64'd0);
    @(negedge clk);
    chk("fetch_after_idle", 64'({cu_state, cu_im_req}), 64'({3'd1, 1'b1}));
    #2 rst_n = 1'b0;
    #1 chk_reset_outputs();

    // Directed instructions, then a random stream ending in an illegal encoding.
    prog.push_back(mk(I_ADD, 1, 2, 0, 0, 0));
    prog.push_back(mk(I_LD, 2, 7, 0, 5, 0));
    prog.push_back(mk(I_SD, 0, 2, 4, 23, 0));
    prog.push_back(mk(I_ADD, 1, 2, 0, 0, 0));
    prog.push_back(mk(I_SUB, 1, 0, 2, 0, 3));
    prog.push_back(mk(I_ADD, 0, 5, 6, 0, 1));
    prog.push_back(mk(I_LD, 0, 3, 0, -1, 2));
    for (int i = 0; i < 30; i++) prog.push_back(rand_instr());
    bi = mk(I_BAD, 0, 0, 0, 0, 1);
    bi.raw = 32'h0200_00B3;
    prog.push_back(bi);
    n = prog.size();
    @(negedge clk);
    rst_n = 1'b1;
    model_pc = RPC;
    fork
      drive(n);
      monitor(n);
    join
    chk("sb_drained_1", 64'(sb.size()), 64'd0);

    rst_n = 1'b0;
    #1 chk_reset_outputs();
    prog.push_back(mk(I_LD, 5, 3, 0, -8, 0));
    prog.push_back(mk(I_ADD, 3, 1, 2, 0, 1));
    prog.push_back(mk(I_ADDI, 3, 0, 0, -1, 0));
    prog.push_back(mk(I_SD, 0, 9, 31, -2048, 2));
    n = prog.size();
`ifndef CU_ADDI_EN
    n = n - 1;
`endif
    @(negedge clk);
    rst_n = 1'b1;
    model_pc = RPC;
    fork
      drive(n);
      monitor(n);
    join
    chk("sb_drained_2", 64'(sb.size()), 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
